// File: rtl/traffic_lamp_guard.sv
// Purpose : safety output stage between the phase sequencer and the lamp lines.
// Latency : pattern -> lamp is 2 cycles (input register plus lamp register).
// Backpr. : none; pattern is sampled every cycle and never stalled.
//
// Ports:
//   clk, reset  - single clock, synchronous active-high reset
//   pattern     - requested lamps, [5:3] approach A {r,a,g}, [2:0] approach B {r,a,g}
//   fault_clr   - operator clear, honoured only in FLASH with a legal pattern
//   lamp        - registered lamp drive, same layout as pattern
//   fault       - sticky failsafe indication
//   fault_code  - violation type latched at trip (01 one-hot, 10 conflict, 11 both)
//   state       - 00 ALL_RED, 01 RUN, 10 FLASH
// Optional: define TRAFFIC_LAMP_DIM_EN to add the dim input and the PWM lamp
// dimmer (parameter DIM_DUTY, lit while pwm count < DIM_DUTY out of 4).
module traffic_lamp_guard #(
    parameter int MIN_DWELL      = 4,
    parameter int FAULT_CYCLES   = 3,
    parameter int STARTUP_CYCLES = 8,
    parameter int FLASH_HALF     = 5
`ifdef TRAFFIC_LAMP_DIM_EN
    ,
    parameter int DIM_DUTY       = 2
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] pattern,
    input  logic       fault_clr,
`ifdef TRAFFIC_LAMP_DIM_EN
    input  logic       dim,
`endif
    output logic [5:0] lamp,
    output logic       fault,
    output logic [1:0] fault_code,
    output logic [1:0] state
);

    localparam int VW = $clog2(FAULT_CYCLES + 1);
    localparam int DW = $clog2(MIN_DWELL + 1);
    localparam int SW = $clog2(STARTUP_CYCLES + 1);
    localparam int FW = $clog2(FLASH_HALF + 1);

    localparam logic [5:0] LAMP_ALL_RED = 6'b100100;
    localparam logic [5:0] LAMP_AMBERS  = 6'b010010;

    typedef enum logic [1:0] {
        ST_ALL_RED = 2'b00,
        ST_RUN     = 2'b01,
        ST_FLASH   = 2'b10
    } state_t;

    state_t          st_q, st_d;
    logic [5:0]      pat_q;
    logic [5:0]      lamp_q, lamp_d;
    logic            fault_q, fault_d;
    logic [1:0]      code_q, code_d;
    logic [VW-1:0]   viol_cnt_q, viol_cnt_d;
    logic [1:0]      viol_type_q, viol_type_d;
    logic [DW-1:0]   dwell_q, dwell_d;
    logic [SW-1:0]   start_cnt_q, start_cnt_d;
    logic [FW-1:0]   flash_cnt_q, flash_cnt_d;
    logic            flash_a_q, flash_a_d;

    logic            ohv, conf, legal, trip, accept;

    function automatic logic onehot3(input logic [2:0] f);
        return (f == 3'b001) || (f == 3'b010) || (f == 3'b100);
    endfunction

    always_comb begin
        ohv    = !onehot3(pat_q[5:3]) || !onehot3(pat_q[2:0]);
        conf   = (pat_q[5:3] != 3'b100) && (pat_q[2:0] != 3'b100);
        legal  = !ohv && !conf;
        // The trip looks at the registered count, so the pattern of the
        // tripping cycle itself may already be legal again; the trip wins.
        trip   = (st_q == ST_RUN) && (viol_cnt_q == VW'(FAULT_CYCLES));
        accept = (st_q == ST_RUN) && !trip && legal && (pat_q != lamp_q)
                 && (dwell_q == DW'(MIN_DWELL));
    end

    // Violation filter runs in every state; the most recent illegal type is
    // remembered so the trip can report the cycle that completed the run.
    always_comb begin
        viol_cnt_d  = viol_cnt_q;
        viol_type_d = viol_type_q;
        if (legal) begin
            viol_cnt_d = '0;
        end else begin
            viol_type_d = {conf, ohv};
            if (viol_cnt_q != VW'(FAULT_CYCLES))
                viol_cnt_d = viol_cnt_q + VW'(1);
        end
    end

    always_comb begin
        st_d        = st_q;
        lamp_d      = lamp_q;
        fault_d     = fault_q;
        code_d      = code_q;
        dwell_d     = dwell_q;
        start_cnt_d = start_cnt_q;
        flash_cnt_d = flash_cnt_q;
        flash_a_d   = flash_a_q;
        case (st_q)
            ST_ALL_RED: begin
                lamp_d  = LAMP_ALL_RED;
                // Saturated dwell lets the first legal pattern in RUN show at once.
                dwell_d = DW'(MIN_DWELL);
                if (start_cnt_q == SW'(STARTUP_CYCLES - 1)) begin
                    st_d        = ST_RUN;
                    start_cnt_d = '0;
                end else begin
                    start_cnt_d = start_cnt_q + SW'(1);
                end
            end
            ST_RUN: begin
                if (trip) begin
                    st_d        = ST_FLASH;
                    fault_d     = 1'b1;
                    code_d      = viol_type_q;
                    flash_cnt_d = '0;
                    flash_a_d   = 1'b1;
                    lamp_d      = LAMP_AMBERS;
                end else if (accept) begin
                    lamp_d  = pat_q;
                    dwell_d = DW'(1);
                end else if (dwell_q != DW'(MIN_DWELL)) begin
                    dwell_d = dwell_q + DW'(1);
                end
            end
            ST_FLASH: begin
                if (fault_clr && legal) begin
                    st_d        = ST_ALL_RED;
                    fault_d     = 1'b0;
                    code_d      = 2'b00;
                    start_cnt_d = '0;
                    lamp_d      = LAMP_ALL_RED;
                end else begin
                    if (flash_cnt_q == FW'(FLASH_HALF - 1)) begin
                        flash_cnt_d = '0;
                        flash_a_d   = !flash_a_q;
                    end else begin
                        flash_cnt_d = flash_cnt_q + FW'(1);
                    end
                    lamp_d = {1'b0, flash_a_d, 2'b00, flash_a_d, 1'b0};
                end
            end
            default: begin
                st_d        = ST_ALL_RED;
                lamp_d      = LAMP_ALL_RED;
                start_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q        <= ST_ALL_RED;
            pat_q       <= LAMP_ALL_RED;
            lamp_q      <= LAMP_ALL_RED;
            fault_q     <= 1'b0;
            code_q      <= 2'b00;
            viol_cnt_q  <= '0;
            viol_type_q <= 2'b00;
            dwell_q     <= '0;
            start_cnt_q <= '0;
            flash_cnt_q <= '0;
            flash_a_q   <= 1'b0;
        end else begin
            st_q        <= st_d;
            pat_q       <= pattern;
            lamp_q      <= lamp_d;
            fault_q     <= fault_d;
            code_q      <= code_d;
            viol_cnt_q  <= viol_cnt_d;
            viol_type_q <= viol_type_d;
            dwell_q     <= dwell_d;
            start_cnt_q <= start_cnt_d;
            flash_cnt_q <= flash_cnt_d;
            flash_a_q   <= flash_a_d;
        end
    end

    assign fault      = fault_q;
    assign fault_code = code_q;
    assign state      = st_q;

`ifdef TRAFFIC_LAMP_DIM_EN
    // Dimming is a pure output gate; lamp_q keeps the undimmed value so the
    // accept comparison is never disturbed by the PWM phase.
    logic [1:0] pwm_cnt_q;
    logic [5:0] lamp_drv_q;
    logic       pwm_on;

    assign pwm_on = !dim || (int'(pwm_cnt_q) < DIM_DUTY);

    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt_q  <= 2'd0;
            lamp_drv_q <= LAMP_ALL_RED;
        end else begin
            pwm_cnt_q  <= pwm_cnt_q + 2'd1;
            lamp_drv_q <= lamp_d & {6{pwm_on}};
        end
    end

    assign lamp = lamp_drv_q;
`else
    assign lamp = lamp_q;
`endif

endmodule

// File: tb/tb_traffic_lamp_guard.sv
// Purpose : randomized and directed bench for traffic_lamp_guard against a behavioural model.
// Latency : model is stepped once per clock edge and compared 1 ns after it.
// Backpr. : none; the bench drives one pattern per cycle.
module tb_traffic_lamp_guard;

    localparam int MIN_DWELL      = 4;
    localparam int FAULT_CYCLES   = 3;
    localparam int STARTUP_CYCLES = 8;
    localparam int FLASH_HALF     = 5;
`ifdef TRAFFIC_LAMP_DIM_EN
    localparam int DIM_DUTY       = 2;
    logic dim;
`endif

    logic       clk;
    logic       reset;
    logic [5:0] pattern;
    logic       fault_clr;
    logic [5:0] lamp;
    logic       fault;
    logic [1:0] fault_code;
    logic [1:0] state;

    int n_checks;
    int n_fail;

    traffic_lamp_guard #(
        .MIN_DWELL      (MIN_DWELL),
        .FAULT_CYCLES   (FAULT_CYCLES),
        .STARTUP_CYCLES (STARTUP_CYCLES),
        .FLASH_HALF     (FLASH_HALF)
`ifdef TRAFFIC_LAMP_DIM_EN
        ,
        .DIM_DUTY       (DIM_DUTY)
`endif
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pattern    (pattern),
        .fault_clr  (fault_clr),
`ifdef TRAFFIC_LAMP_DIM_EN
        .dim        (dim),
`endif
        .lamp       (lamp),
        .fault      (fault),
        .fault_code (fault_code),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural reference ----------------
    // Tracks time spent in each mode, the length of the current illegal run
    // and the time since the last displayed change.
    logic [5:0] m_pat_q;
    logic [5:0] m_lamp;
    logic [5:0] m_lamp_out;
    logic       m_fault;
    logic [1:0] m_code;
    logic [1:0] m_state;
    logic [1:0] m_last_type;
    int         m_age;
    int         m_run;
    int         m_since;
`ifdef TRAFFIC_LAMP_DIM_EN
    int         m_pwm;
`endif

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic model_step();
        logic ohv, conf, lgl;
        if (reset) begin
            m_pat_q     = 6'b100100;
            m_lamp      = 6'b100100;
            m_lamp_out  = 6'b100100;
            m_fault     = 1'b0;
            m_code      = 2'b00;
            m_state     = 2'b00;
            m_last_type = 2'b00;
            m_age       = 0;
            m_run       = 0;
            m_since     = 0;
`ifdef TRAFFIC_LAMP_DIM_EN
            m_pwm       = 0;
`endif
            return;
        end
        ohv  = ($countones(m_pat_q[5:3]) != 1) || ($countones(m_pat_q[2:0]) != 1);
        conf = (m_pat_q[5:3] != 3'b100) && (m_pat_q[2:0] != 3'b100);
        lgl  = !ohv && !conf;
        case (m_state)
            2'b00: begin
                m_lamp = 6'b100100;
                if (m_age == STARTUP_CYCLES - 1) begin
                    m_state = 2'b01;
                    m_age   = 0;
                    m_since = MIN_DWELL;
                end else begin
                    m_age++;
                end
            end
            2'b01: begin
                if (m_run >= FAULT_CYCLES) begin
                    m_state = 2'b10;
                    m_fault = 1'b1;
                    m_code  = m_last_type;
                    m_age   = 0;
                    m_lamp  = 6'b010010;
                end else if (lgl && m_pat_q != m_lamp && m_since >= MIN_DWELL) begin
                    m_lamp  = m_pat_q;
                    m_since = 1;
                end else begin
                    m_since++;
                end
            end
            default: begin
                if (fault_clr && lgl) begin
                    m_state = 2'b00;
                    m_fault = 1'b0;
                    m_code  = 2'b00;
                    m_age   = 0;
                    m_lamp  = 6'b100100;
                end else begin
                    m_age++;
                    m_lamp = (((m_age / FLASH_HALF) % 2) == 0) ? 6'b010010 : 6'b000000;
                end
            end
        endcase
        if (!lgl) m_last_type = {conf, ohv};
        m_run   = lgl ? 0 : m_run + 1;
        m_pat_q = pattern;
`ifdef TRAFFIC_LAMP_DIM_EN
        m_lamp_out = (!dim || m_pwm < DIM_DUTY) ? m_lamp : 6'b000000;
        m_pwm      = (m_pwm + 1) % 4;
`else
        m_lamp_out = m_lamp;
`endif
    endtask

    // One clock cycle: drive, clock, step model, compare.
    task automatic cyc(input logic [5:0] p, input logic clr, input logic rst);
        pattern   = p;
        fault_clr = clr;
        reset     = rst;
`ifdef TRAFFIC_LAMP_DIM_EN
        dim       = 1'($urandom_range(0, 1));
`endif
        @(posedge clk);
        model_step();
        #1;
        chk("lamp",  {2'b00, lamp},       {2'b00, m_lamp_out});
        chk("fault", {7'b0, fault},       {7'b0, m_fault});
        chk("code",  {6'b0, fault_code},  {6'b0, m_code});
        chk("state", {6'b0, state},       {6'b0, m_state});
    endtask

    task automatic hold(input logic [5:0] p, input logic clr, input int n);
        for (int i = 0; i < n; i++) cyc(p, clr, 1'b0);
    endtask

    logic [5:0] legal_pats [5];
    logic [5:0] rp;

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        pattern   = 6'b001100;
        fault_clr = 1'b0;
`ifdef TRAFFIC_LAMP_DIM_EN
        dim       = 1'b0;
`endif
        legal_pats[0] = 6'b100100;
        legal_pats[1] = 6'b100010;
        legal_pats[2] = 6'b100001;
        legal_pats[3] = 6'b010100;
        legal_pats[4] = 6'b001100;

        // Reset and startup with a green request waiting.
        cyc(6'b001100, 1'b0, 1'b1);
        cyc(6'b001100, 1'b0, 1'b1);
        chk("rst_state", {6'b0, state}, 8'h00);
        chk("rst_fault", {7'b0, fault}, 8'h00);
        chk("rst_code",  {6'b0, fault_code}, 8'h00);
        hold(6'b001100, 1'b0, STARTUP_CYCLES - 1);
        chk("startup_state", {6'b0, state}, 8'h00);
        hold(6'b001100, 1'b0, 2);
        chk("startup_state_run", {6'b0, state}, 8'h01);
        hold(6'b001100, 1'b0, 6);

        // Dwell: amber accepted at once, next change waits for the dwell.
        cyc(6'b010100, 1'b0, 1'b0);
        hold(6'b100001, 1'b0, 8);

        // Conflict glitch shorter than the filter.
        hold(6'b001001, 1'b0, FAULT_CYCLES - 1);
        hold(6'b100001, 1'b0, 4);
        chk("glitch_fault", {7'b0, fault}, 8'h00);

        // Persistent conflict trips to FLASH.
        hold(6'b001001, 1'b0, FAULT_CYCLES + 2);
        chk("trip_fault", {7'b0, fault}, 8'h01);
        chk("trip_code",  {6'b0, fault_code}, 8'h02);
        hold(6'b001001, 1'b0, 3 * FLASH_HALF);

        // Clear with an illegal pattern is ignored, then a legal clear exits.
        hold(6'b011100, 1'b1, 3);
        chk("clr_illegal_state", {6'b0, state}, 8'h02);
        hold(6'b100100, 1'b1, 2);
        chk("clr_state", {6'b0, state}, 8'h00);
        hold(6'b100100, 1'b0, STARTUP_CYCLES + 4);

        // Reset in the middle of FLASH.
        hold(6'b011100, 1'b0, FAULT_CYCLES + 4);
        chk("flash_before_rst", {6'b0, state}, 8'h02);
        cyc(6'b011100, 1'b0, 1'b1);
        chk("midrst_state", {6'b0, state}, 8'h00);
        chk("midrst_fault", {7'b0, fault}, 8'h00);
        hold(6'b100010, 1'b0, STARTUP_CYCLES + 6);

        // Randomized segments of legal and arbitrary patterns.
        for (int seg = 0; seg < 700; seg++) begin
            int len;
            if ($urandom_range(0, 9) < 6) rp = legal_pats[$urandom_range(0, 4)];
            else                          rp = 6'($urandom);
            len = $urandom_range(1, 7);
            for (int k = 0; k < len; k++)
                cyc(rp, ($urandom_range(0, 4) == 0), ($urandom_range(0, 399) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
